d_flip_flop: RTL and testbench
==============================

Name: d_flip_flop

Overview:
- Edge-triggered D-type storage element: captures `D` on the rising edge of `clk` and presents it on `Q`.
- Reset is synchronous and active-high; it clears the stored value to a programmable constant.
- Generalised to a WIDTH-bit register with an optional STAGES-deep delay line. Defaults (WIDTH=1, STAGES=1) give a plain single-bit DFF.
- Leaf cell, used wherever a registered bit or bus, or a fixed-latency retiming chain, is needed.

Parameters:
- WIDTH, 1, data width of `D` and `Q` in bits (must be ≥1).
- STAGES, 1, number of cascaded register stages; input-to-output latency in clock cycles (must be ≥1).
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into every stage while reset is sampled high.

Ports:
- clk  input  1  sole clock; all state updates on its rising edge.
- asyncReset  input  1  reset, synchronous and active-high. The port keeps the codebase name but is sampled only on the rising edge of `clk`.
- D  input  WIDTH  data to capture.
- Q  output  WIDTH  registered data; driven directly from the last stage flop, with no combinational path from `D` or `asyncReset`.

Behaviour:
- Single clock domain; no other edges or levels change state.
- On each rising edge of `clk`:
  - If `asyncReset`==1, every stage loads RESET_VALUE, so `Q`=RESET_VALUE after that edge.
  - Otherwise, stage0 ← `D` and stage[i] ← stage[i-1] for i=1..STAGES-1; `Q` = stage[STAGES-1].
- Latency: a `D` value sampled at edge n appears on `Q` after edge n+STAGES-1, i.e. it is visible for the cycle following edge n+STAGES-1. With STAGES=1, `Q` follows `D` one edge later.
- Reset priority: reset dominates `D` at the same edge.
- Reset with no clock edge: asserting or deasserting `asyncReset` while `clk` is static (high or low) has no effect; `Q` holds.
- Reset mid-stream: all in-flight stage contents are discarded in one edge; no partial flush.
- Reset deassertion: the first edge with reset low captures `D`. With STAGES>1, `Q` shows RESET_VALUE until the pipeline refills, i.e. for STAGES-1 further edges.
- Between edges: `Q` is stable; changes on `D` are ignored.
- Power-up: stage contents are unspecified (X in simulation) until the first edge with reset high or until STAGES edges of valid data. No initial-value assignment is relied on.
- Parameters outside legal range (WIDTH<1, STAGES<1) stop elaboration with an error.

Decomposition:
- Shared package: none required. The legal-range checks on WIDTH and STAGES live locally as elaboration assertions.
- One natural sub-module, `d_flip_flop_stage`: a single WIDTH-bit register with synchronous active-high reset to RESET_VALUE.
- The top generates STAGES instances of `d_flip_flop_stage` in a chain.

Test Plan:
- Reset capture: D=0, asyncReset=1, rising clk → Q=0 (RESET_VALUE). Then asyncReset=0, D=0, rising clk → Q=0.
- Data capture: asyncReset=0, D=1, rising clk → Q=1. Toggling D between edges leaves Q unchanged until the next rising edge.
- Reset without edge: with Q=1, raise asyncReset=1 while clk is held high, then lower clk → Q stays 1. At the next rising clk with reset still 1 → Q=0.
- Reset-over-data priority: D=1, asyncReset=1 at the same rising edge → Q=0.
- Latency (WIDTH=8, STAGES=3, RESET_VALUE=8'hA5):
  - Reset for one edge → Q=8'hA5.
  - Release reset and drive D=8'h01, 8'h02, 8'h03 on successive edges → Q=A5, A5, 01, 02, 03.
  - Reasserting reset on any edge → Q=A5 after that edge.

Source files
------------

// File: rtl/d_flip_flop_stage.sv
// Single WIDTH-bit register stage with synchronous active-high reset to RESET_VALUE.
module d_flip_flop_stage #(
    parameter int unsigned       WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Capture d each rising edge; reset has priority and loads the constant.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= RESET_VALUE;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/d_flip_flop.sv
// WIDTH-bit D flip-flop generalised to a STAGES-deep retiming chain.
// Q comes straight from the last stage flop; latency from D to Q is STAGES edges.
module d_flip_flop #(
    parameter int               WIDTH       = 1,
    parameter int               STAGES      = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             asyncReset,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    // Legal-range checks on the geometry parameters.
    if (WIDTH < 1) begin : g_bad_width
        $error("d_flip_flop: WIDTH must be >= 1");
    end
    if (STAGES < 1) begin : g_bad_stages
        $error("d_flip_flop: STAGES must be >= 1");
    end

    // link[0] is the input; link[i+1] is the output of stage i.
    logic [WIDTH-1:0] link [STAGES+1];

    assign link[0] = D;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        d_flip_flop_stage #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_stage (
            .clk   (clk),
            .reset (asyncReset),
            .d     (link[i]),
            .q     (link[i+1])
        );
    end

    assign Q = link[STAGES];

endmodule

// File: tb/tb_d_flip_flop.sv
// Self-checking bench for d_flip_flop: a default 1-bit instance and an
// 8-bit, 3-stage instance with reset value 8'hA5, checked against queue models.
module tb_d_flip_flop;

    localparam logic [7:0] RV8 = 8'hA5;

    logic       clk;
    logic       rst;
    logic       d1;
    logic       q1;
    logic [7:0] d8;
    logic [7:0] q8;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: expected 1-bit output and the 3-deep delay line
    // (newest entry at the front, output taken from the back).
    logic       exp1;
    logic [7:0] pipe[$];

    d_flip_flop u_dut1 (
        .clk        (clk),
        .asyncReset (rst),
        .D          (d1),
        .Q          (q1)
    );

    d_flip_flop #(
        .WIDTH       (8),
        .STAGES      (3),
        .RESET_VALUE (RV8)
    ) u_dut8 (
        .clk        (clk),
        .asyncReset (rst),
        .D          (d8),
        .Q          (q8)
    );

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Apply the model's rule for one rising edge using the current inputs, then raise clk.
    task automatic rise();
        if (rst) begin
            exp1 = 1'b0;
            pipe = '{RV8, RV8, RV8};
        end else begin
            exp1 = d1;
            pipe.push_front(d8);
            void'(pipe.pop_back());
        end
        clk = 1'b1;
        #1;
    endtask

    task automatic fall();
        #4;
        clk = 1'b0;
        #5;
    endtask

    task automatic cycle();
        rise();
        fall();
    endtask

    task automatic check_both(input string tag);
        check_eq({tag, "_q1"}, {7'b0, q1}, {7'b0, exp1});
        check_eq({tag, "_q8"}, q8, pipe[2]);
    endtask

    initial begin
        clk  = 1'b0;
        rst  = 1'b0;
        d1   = 1'b0;
        d8   = 8'h00;
        exp1 = 1'bx;
        pipe = '{8'hxx, 8'hxx, 8'hxx};
        #10;

        // Reset capture
        rst = 1'b1; d1 = 1'b0; d8 = 8'h3C;
        rise();
        check_eq("reset_q1", {7'b0, q1}, 8'h00);
        check_eq("reset_q8", q8, RV8);
        fall();

        // First edge after release with D=0
        rst = 1'b0; d1 = 1'b0; d8 = 8'h01;
        rise();
        check_eq("release_q1", {7'b0, q1}, 8'h00);
        check_eq("release_q8", q8, RV8);
        fall();

        // Data capture, then latency refill with 02, 03
        d1 = 1'b1; d8 = 8'h02;
        rise();
        check_eq("capture_q1", {7'b0, q1}, 8'h01);
        check_eq("lat2_q8", q8, RV8);
        fall();

        // Toggling D between edges leaves Q alone
        d1 = 1'b0; #2; d1 = 1'b1; #2; d1 = 1'b0;
        d8 = 8'h77; #1;
        check_eq("hold_q1", {7'b0, q1}, 8'h01);
        check_eq("hold_q8", q8, RV8);
        d1 = 1'b1; d8 = 8'h03;
        rise();
        check_eq("lat3_q8", q8, 8'h01);
        check_both("lat3");
        fall();

        d8 = 8'h00;
        cycle();
        check_eq("lat4_q8", q8, 8'h02);
        cycle();
        check_eq("lat5_q8", q8, 8'h03);
        check_eq("lat5_q1", {7'b0, q1}, 8'h01);

        // Reset toggled while clk is static high, then low: no effect
        d1 = 1'b1; d8 = 8'h5A;
        rise();
        check_both("pre_static");
        rst = 1'b1;
        #3;
        check_eq("static_hi_q1", {7'b0, q1}, 8'h01);
        check_eq("static_hi_q8", q8, 8'h00);
        #1; clk = 1'b0; #3;
        check_eq("static_lo_q1", {7'b0, q1}, 8'h01);
        rst = 1'b0; #2; rst = 1'b1; #2;
        check_eq("static_lo_q8", q8, 8'h00);
        #3;

        // Reset-over-data priority at the same edge, mid-stream flush
        d1 = 1'b1; d8 = 8'hFF;
        rise();
        check_eq("prio_q1", {7'b0, q1}, 8'h00);
        check_eq("flush_q8", q8, RV8);
        fall();

        // Randomized traffic with occasional reset
        for (int i = 0; i < 300; i++) begin
            rst = ($urandom_range(0, 7) == 0);
            d1  = 1'($urandom);
            d8  = 8'($urandom);
            rise();
            check_both("rand");
            fall();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
